// File: rtl/pid_mult_scheduler_pkg.sv
// Shared fixed-point constants, sequencer state encoding and saturation helper.
// Used by the PID multiplier scheduler and the other fixed-point blocks.
package pid_mult_scheduler_pkg;

  localparam int unsigned MAGNITUD = 17;
  localparam int unsigned DECIMAL  = 0;
  localparam int unsigned N        = MAGNITUD + DECIMAL + 1;

  localparam logic signed [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_P = 3'd1,
    MUL_I = 3'd2,
    MUL_D = 3'd3,
    SUM   = 3'd4
  } state_t;

  // Clamp an (N+2)-bit signed value into the N-bit signed range.
  function automatic logic signed [N-1:0] sat(input logic signed [N+1:0] x);
    if (x > (N+2)'(SAT_MAX)) begin
      return SAT_MAX;
    end else if (x < (N+2)'(SAT_MIN)) begin
      return SAT_MIN;
    end else begin
      return x[N-1:0];
    end
  endfunction

endpackage

// File: rtl/pid_mult_scheduler_if.sv
// Sample/gain inputs and control-effort outputs of the PID multiplier scheduler.
//   master: drives muestra, error, kp, ki, kd; observes u, u_valid, busy, perdida
//   slave : the scheduler itself
interface pid_mult_scheduler_if;
  import pid_mult_scheduler_pkg::*;

  logic                muestra;
  logic signed [N-1:0] error;
  logic signed [N-1:0] kp;
  logic signed [N-1:0] ki;
  logic signed [N-1:0] kd;
  logic signed [N-1:0] u;
  logic                u_valid;
  logic                busy;
  logic                perdida;

  modport master (
    output muestra, error, kp, ki, kd,
    input  u, u_valid, busy, perdida
  );

  modport slave (
    input  muestra, error, kp, ki, kd,
    output u, u_valid, busy, perdida
  );

endinterface

// File: rtl/Multiplicacion.sv
// Shared signed fixed-point multiplier (combinational).
//   a, b : N-bit signed operands, Decimal fractional bits
//   y    : full 2N-bit product, arithmetic shift by Decimal, saturated to N bits
module Multiplicacion #(
  parameter int unsigned Magnitud = 17,
  parameter int unsigned Decimal  = 0,
  localparam int unsigned N       = Magnitud + Decimal + 1
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] y
);

  localparam logic signed [2*N-1:0] LIM_HI = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] LIM_LO = ~LIM_HI;

  logic signed [2*N-1:0] prod;
  logic signed [2*N-1:0] shifted;

  // Operands are sign-extended to the 2N-bit context before multiplying.
  always_comb begin
    prod    = (2*N)'(a) * (2*N)'(b);
    shifted = prod >>> Decimal;
    if (shifted > LIM_HI) begin
      y = LIM_HI[N-1:0];
    end else if (shifted < LIM_LO) begin
      y = LIM_LO[N-1:0];
    end else begin
      y = shifted[N-1:0];
    end
  end

endmodule

// File: rtl/pid_mult_scheduler.sv
// Time-multiplexes one fixed-point multiplier over the P, I and D terms.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset, clears all history
//   bus     : slave side -- muestra/error/kp/ki/kd in; u/u_valid/busy/perdida out
// A strobe accepted in IDLE yields a saturated u with a u_valid pulse 4 cycles later.
module pid_mult_scheduler
  import pid_mult_scheduler_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  pid_mult_scheduler_if.slave  bus
);

  state_t              state;
  logic signed [N-1:0] kp_l, ki_l, kd_l, e_l;
  logic signed [N-1:0] e_prev, i_acc, d_reg;
  logic signed [N-1:0] p_reg, i_reg, d_prod;
  logic signed [N-1:0] u_r;
  logic                u_valid_r, busy_r, perdida_r;

  logic signed [N-1:0] op_a, op_b, mult_y;
  logic signed [N+1:0] diff_w, iacc_w, sum_w;

  // Operand mux: one product per state, zero while idle.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      MUL_P:   begin op_a = kp_l; op_b = e_l;   end
      MUL_I:   begin op_a = ki_l; op_b = i_acc; end
      MUL_D:   begin op_a = kd_l; op_b = d_reg; end
      default: begin op_a = '0;   op_b = '0;    end
    endcase
  end

  // Wide intermediates so the saturating clamp sees the true value.
  always_comb begin
    diff_w = (N+2)'(bus.error) - (N+2)'(e_prev);
    iacc_w = (N+2)'(i_acc) + (N+2)'(bus.error);
    sum_w  = (N+2)'(p_reg) + (N+2)'(i_reg) + (N+2)'(d_prod);
  end

  Multiplicacion #(
    .Magnitud (MAGNITUD),
    .Decimal  (DECIMAL)
  ) u_mult (
    .a (op_a),
    .b (op_b),
    .y (mult_y)
  );

  // Sequencer with registered outputs; busy tracks (state != IDLE) after each edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      kp_l      <= '0;
      ki_l      <= '0;
      kd_l      <= '0;
      e_l       <= '0;
      e_prev    <= '0;
      i_acc     <= '0;
      d_reg     <= '0;
      p_reg     <= '0;
      i_reg     <= '0;
      d_prod    <= '0;
      u_r       <= '0;
      u_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      perdida_r <= 1'b0;
    end else begin
      u_valid_r <= 1'b0;
      // A strobe during a sequence is dropped but remembered.
      if (bus.muestra && (state != IDLE)) begin
        perdida_r <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.muestra) begin
            kp_l   <= bus.kp;
            ki_l   <= bus.ki;
            kd_l   <= bus.kd;
            e_l    <= bus.error;
            d_reg  <= sat(diff_w);
            e_prev <= bus.error;
            i_acc  <= sat(iacc_w);
            state  <= MUL_P;
            busy_r <= 1'b1;
          end
        end
        MUL_P: begin
          p_reg <= mult_y;
          state <= MUL_I;
        end
        MUL_I: begin
          i_reg <= mult_y;
          state <= MUL_D;
        end
        MUL_D: begin
          d_prod <= mult_y;
          state  <= SUM;
        end
        SUM: begin
          u_r       <= sat(sum_w);
          u_valid_r <= 1'b1;
          state     <= IDLE;
          busy_r    <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.u       = u_r;
  assign bus.u_valid = u_valid_r;
  assign bus.busy    = busy_r;
  assign bus.perdida = perdida_r;

endmodule

// File: tb/tb_pid_mult_scheduler.sv
// Self-checking bench for pid_mult_scheduler: directed scenarios plus
// randomized samples against an arithmetic reference model of the PID loop.
module tb_pid_mult_scheduler;
  import pid_mult_scheduler_pkg::*;

  localparam longint SMAX = (longint'(1) << (N-1)) - 1;
  localparam longint SMIN = -(longint'(1) << (N-1));

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  // Reference history of the control loop.
  longint m_eprev = 0;
  longint m_iacc  = 0;

  pid_mult_scheduler_if bus();

  pid_mult_scheduler dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sat_l(input longint x);
    if (x > SMAX) return SMAX;
    if (x < SMIN) return SMIN;
    return x;
  endfunction

  function automatic longint mult_l(input longint a, input longint b);
    return sat_l((a * b) >>> DECIMAL);
  endfunction

  function automatic longint rnd(input int r);
    return longint'($urandom_range(0, 2 * r)) - longint'(r);
  endfunction

  task automatic model_sample(input longint e, input longint p, input longint i,
                              input longint d, output longint u_exp);
    longint dv;
    dv      = sat_l(e - m_eprev);
    m_eprev = e;
    m_iacc  = sat_l(m_iacc + e);
    u_exp   = sat_l(mult_l(p, e) + mult_l(i, m_iacc) + mult_l(d, dv));
  endtask

  task automatic do_reset();
    bus.muestra = 1'b0;
    bus.error = '0; bus.kp = '0; bus.ki = '0; bus.kd = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    m_eprev = 0;
    m_iacc  = 0;
  endtask

  // One strobe; checks the busy window, the single pulse at +4 and the value.
  task automatic run_sample(input longint e, input longint p, input longint i,
                            input longint d, input bit scramble, output longint u_exp);
    bit bad;
    model_sample(e, p, i, d, u_exp);
    bus.error = N'(e); bus.kp = N'(p); bus.ki = N'(i); bus.kd = N'(d);
    bus.muestra = 1'b1;
    tick();
    bus.muestra = 1'b0;
    if (scramble) begin
      bus.error = N'(rnd(131071)); bus.kp = N'(rnd(131071));
      bus.ki = N'(rnd(131071));    bus.kd = N'(rnd(131071));
    end
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (bus.busy !== 1'b1 || bus.u_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad) $display("FAIL seq_window: busy/u_valid wrong during sequence (e=%0d)", e);
    else passed++;
    checks++;
    if (bus.u_valid !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL pulse_at_4: u_valid=%b busy=%b, required 1/0", bus.u_valid, bus.busy);
    else passed++;
    checks++;
    if (longint'(bus.u) !== u_exp)
      $display("FAIL u_value: u=%0d required %0d (e=%0d kp=%0d ki=%0d kd=%0d)",
               bus.u, u_exp, e, p, i, d);
    else passed++;
  endtask

  task automatic test_reset();
    bus.muestra = 1'b0;
    bus.error = '0; bus.kp = '0; bus.ki = '0; bus.kd = '0;
    reset_n = 1'b0;
    #12;
    checks++;
    if (bus.u !== '0 || bus.u_valid !== 1'b0 || bus.busy !== 1'b0 || bus.perdida !== 1'b0)
      $display("FAIL reset_state: u=%0d u_valid=%b busy=%b perdida=%b, required all 0",
               bus.u, bus.u_valid, bus.busy, bus.perdida);
    else passed++;
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.u !== '0 || bus.u_valid !== 1'b0 || bus.busy !== 1'b0 || bus.perdida !== 1'b0)
      $display("FAIL idle_after_reset: u=%0d u_valid=%b busy=%b perdida=%b, required all 0",
               bus.u, bus.u_valid, bus.busy, bus.perdida);
    else passed++;
  endtask

  task automatic test_proportional();
    longint ue;
    do_reset();
    run_sample(100, 18, 0, 0, 1'b0, ue);
    checks++;
    if (bus.u !== N'(1800)) $display("FAIL p_term: u=%0d required 1800", bus.u);
    else passed++;
    tick();
    checks++;
    if (bus.u_valid !== 1'b0 || bus.u !== N'(1800))
      $display("FAIL u_hold: u_valid=%b u=%0d, required 0/1800", bus.u_valid, bus.u);
    else passed++;
  endtask

  task automatic test_integral();
    longint ue;
    longint want[3] = '{20, 40, 60};
    do_reset();
    for (int s = 0; s < 3; s++) begin
      run_sample(10, 0, 2, 0, 1'b0, ue);
      checks++;
      if (longint'(bus.u) !== want[s]) $display("FAIL i_term%0d: u=%0d required %0d", s, bus.u, want[s]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_derivative();
    longint ue;
    do_reset();
    run_sample(50, 0, 0, 3, 1'b0, ue);
    checks++;
    if (bus.u !== N'(150)) $display("FAIL d_term_first: u=%0d required 150", bus.u);
    else passed++;
    run_sample(20, 0, 0, 3, 1'b0, ue);
    checks++;
    if (bus.u !== N'(-90)) $display("FAIL d_term_second: u=%0d required -90", bus.u);
    else passed++;
  endtask

  task automatic test_saturation();
    longint ue;
    do_reset();
    run_sample(200, 1000, 0, 0, 1'b0, ue);
    checks++;
    if (longint'(bus.u) !== SMAX) $display("FAIL sat_pos: u=%0d required %0d", bus.u, SMAX);
    else passed++;
    run_sample(-200, 1000, 0, 0, 1'b0, ue);
    checks++;
    if (longint'(bus.u) !== SMIN) $display("FAIL sat_neg: u=%0d required %0d", bus.u, SMIN);
    else passed++;
    do_reset();
    for (int s = 0; s < 4; s++) begin
      run_sample(131071, 0, 1000, 0, 1'b0, ue);
      checks++;
      if (longint'(bus.u) !== SMAX) $display("FAIL windup%0d: u=%0d required %0d", s, bus.u, SMAX);
      else passed++;
    end
  endtask

  task automatic test_lost_and_abort();
    longint ue;
    int pulses;
    longint u_seen;
    do_reset();
    model_sample(9, 7, 0, 0, ue);
    bus.error = N'(9); bus.kp = N'(7);
    bus.muestra = 1'b1;
    tick();
    bus.muestra = 1'b0;
    tick();
    checks++;
    if (bus.perdida !== 1'b0) $display("FAIL perdida_early: perdida=%b required 0", bus.perdida);
    else passed++;
    bus.muestra = 1'b1;
    tick();
    bus.muestra = 1'b0;
    pulses = 0;
    u_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.u_valid === 1'b1) begin pulses++; u_seen = longint'(bus.u); end
      tick();
    end
    checks++;
    if (pulses != 1 || u_seen !== ue)
      $display("FAIL lost_strobe: pulses=%0d u=%0d, required 1 pulse with %0d", pulses, u_seen, ue);
    else passed++;
    checks++;
    if (bus.perdida !== 1'b1) $display("FAIL perdida_set: perdida=%b required 1", bus.perdida);
    else passed++;
    // Abort in MUL_I with a prior nonzero u on the output.
    bus.error = N'(40); bus.kd = N'(3);
    bus.muestra = 1'b1;
    tick();
    bus.muestra = 1'b0;
    tick();
    reset_n = 1'b0;
    #2;
    checks++;
    if (bus.u !== '0 || bus.u_valid !== 1'b0 || bus.busy !== 1'b0 || bus.perdida !== 1'b0)
      $display("FAIL abort_reset: u=%0d u_valid=%b busy=%b perdida=%b, required all 0",
               bus.u, bus.u_valid, bus.busy, bus.perdida);
    else passed++;
    @(posedge clk);
    #1 reset_n = 1'b1;
    m_eprev = 0;
    m_iacc  = 0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.u_valid === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0) $display("FAIL abort_no_pulse: pulses=%0d required 0", pulses);
    else passed++;
    run_sample(5, 0, 0, 1, 1'b0, ue);
    checks++;
    if (bus.u !== N'(5)) $display("FAIL abort_history: u=%0d required 5", bus.u);
    else passed++;
  endtask

  task automatic test_back_to_back();
    longint ue;
    do_reset();
    // Each call strobes in the cycle where the previous u_valid is high.
    run_sample(300, 4, 1, 2, 1'b0, ue);
    run_sample(-120, 4, 1, 2, 1'b0, ue);
    run_sample(75, 4, 1, 2, 1'b1, ue);
    checks++;
    if (bus.perdida !== 1'b0) $display("FAIL b2b_perdida: perdida=%b required 0", bus.perdida);
    else passed++;
  endtask

  task automatic test_random();
    longint ue;
    longint e, p, i, d;
    do_reset();
    for (int s = 0; s < 24; s++) begin
      if ($urandom_range(0, 1) == 0) begin
        e = rnd(2000); p = rnd(64); i = rnd(64); d = rnd(64);
      end else begin
        e = rnd(131071); p = rnd(131071); i = rnd(131071); d = rnd(131071);
      end
      run_sample(e, p, i, d, 1'($urandom_range(0, 1)), ue);
      repeat ($urandom_range(0, 2)) tick();
    end
    checks++;
    if (bus.perdida !== 1'b0) $display("FAIL rand_perdida: perdida=%b required 0", bus.perdida);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_proportional();
    test_integral();
    test_derivative();
    test_saturation();
    test_lost_and_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pid_mult_scheduler.md
Name: pid_mult_scheduler

Overview:
Time-multiplexes one signed fixed-point multiplier across the P, I and D terms of the servo loop. The sample strobe starts a sequence; the summed, saturated control effort is produced 4 cycles later. The block sits between the error computation and the PWM/servo drive stage, and replaces three parallel multiplier instances.

Parameters:
Magnitud, 17, integer magnitude bits of every operand/result
Decimal, 0, fractional bits of every operand/result
N, Magnitud+Decimal+1, total signed word width (derived; not overridden)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
muestra  in  1  sample strobe, one-cycle pulse per control period
error  in  N  signed loop error (setpoint - position)
kp  in  N  signed proportional gain
ki  in  N  signed integral gain
kd  in  N  signed derivative gain
u  out  N  signed control effort, registered
u_valid  out  1  one-cycle pulse: u updated
busy  out  1  high while a sequence is in progress
perdida  out  1  sticky: strobe arrived while busy

Behaviour:
- One clock domain; reset is asynchronous and active-low. Reset drives u=0, u_valid=0, busy=0, perdida=0, state=IDLE, and clears all internal registers (e_prev, i_acc, products, latched gains).
- Sat(x): clamp to [-2^(N-1), 2^(N-1)-1].
- Mult(a,b): full 2N-bit signed product, arithmetic shift right by Decimal, then Sat.
- States: IDLE -> MUL_P -> MUL_I -> MUL_D -> SUM -> IDLE. Exactly one cycle per state. busy = (state != IDLE).
- Accept: at edge k, if state=IDLE and muestra=1:
  - latch kp, ki, kd and error;
  - d_reg = Sat(error - e_prev), then e_prev = error;
  - i_acc = Sat(i_acc + error), which gives anti-windup by clamping;
  - go to MUL_P.
- Edge k+1: p_reg = Mult(kp_l, e_l). Edge k+2: i_reg = Mult(ki_l, i_acc). Edge k+3: d_prod = Mult(kd_l, d_reg).
- Edge k+4: u = Sat(p_reg + i_reg + d_prod), summed at N+2 bits. u_valid=1 for exactly one cycle. State returns to IDLE.
- Latency strobe-to-u_valid: 4 cycles. Minimum strobe spacing: 5 cycles. A strobe sampled in the cycle where u_valid is high is accepted.
- Multiplier operands are muxed by state. Only one multiply occurs per cycle. In IDLE the operands are held at 0.
- muestra while busy: ignored, sequence unaffected, perdida set to 1. perdida is cleared only by reset.
- Gain or error changes mid-sequence have no effect; latched values are used.
- u holds its value between updates. u_valid is 0 except the single pulse.
- First sample after reset uses e_prev=0 and i_acc=0.
- reset_n asserted mid-sequence aborts immediately. No u_valid is produced. The next sequence starts from a fully cleared history.

Decomposition:
- Shared package/include holds the state encoding (IDLE, MUL_P, MUL_I, MUL_D, SUM), the N derivation, and the saturation limit constants SAT_MAX/SAT_MIN. The same constants are used by the other fixed-point blocks.
- One sub-module: the existing shared fixed-point multiplier Multiplicacion, instantiated once with Magnitud/Decimal passed through. The 2N product, shift and Sat rules above are the required behaviour of that instance path.
- The FSM, accumulator, derivative register and final adder stay in this module.

Test Plan:
- Reset -> u=0, u_valid=0, busy=0, perdida=0. Release reset, then apply idle cycles -> outputs unchanged.
- kp=18, ki=0, kd=0, error=100, muestra at edge k -> busy high edges k+1..k+3, u=1800 with u_valid at edge k+4 only.
- kp=0, ki=2, kd=0, three strobes with error=10, 6 cycles apart -> u=20, 40, 60.
- kp=0, ki=0, kd=3, error=50 then error=20 -> u=150, then u=-90.
- kp=1000, error=200 -> u=131071. error=-200 -> u=-131072. ki=1000 with repeated error=131071 -> i_acc clamps at 131071, u never wraps.
- Strobe at k, second strobe at k+2 -> single u_valid at k+4, perdida=1. reset_n low during MUL_I -> u=0, no pulse. Next strobe (error=5, kd=1) -> u=5, since e_prev was cleared.
